// File: rtl/ahb5_mem_slave_if.sv
// AHB5 subordinate-side bus bundle for ahb5_mem_slave.
// The master modport is the manager/interconnect view; HREADY is the bus-level ready from the interconnect.
interface ahb5_mem_slave_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASTER_WIDTH = 4
);
  logic                    HSEL;
  logic [ADDR_WIDTH-1:0]   HADDR;
  logic [1:0]              HTRANS;
  logic                    HWRITE;
  logic [2:0]              HSIZE;
  logic [2:0]              HBURST;
  logic [DATA_WIDTH/8-1:0] HWSTRB;
  logic [DATA_WIDTH-1:0]   HWDATA;
  logic                    HREADY;
  logic                    HEXCL;
  logic [MASTER_WIDTH-1:0] HMASTER;
  logic                    HREADYOUT;
  logic                    HRESP;
  logic [DATA_WIDTH-1:0]   HRDATA;
  logic                    HEXOKAY;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWSTRB, HWDATA,
           HREADY, HEXCL, HMASTER,
    input  HREADYOUT, HRESP, HRDATA, HEXOKAY
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWSTRB, HWDATA,
           HREADY, HEXCL, HMASTER,
    output HREADYOUT, HRESP, HRDATA, HEXOKAY
  );
endinterface

// File: rtl/ahb5_mem_slave.sv
// AHB5 memory subordinate: word-organised RAM, programmable wait states, two-cycle ERROR.
// Define AHB5_EXCL_EN to build the single-entry exclusive-access monitor.
module ahb5_mem_slave #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH    = 1024,
  parameter int WAIT_STATES  = 0,
  parameter int MASTER_WIDTH = 4
) (
  input logic             HCLK,
  input logic             HRESET,
  ahb5_mem_slave_if.slave bus
);
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int LANE_W     = $clog2(DATA_BYTES);
  localparam int WORD_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] BYTE_RANGE = (ADDR_WIDTH + 1)'(MEM_DEPTH * DATA_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic                    hreadyout_q;
  logic                    hresp_q;
  logic [DATA_WIDTH-1:0]   hrdata_q;

  // Address-phase capture of the transfer currently in its data phase
  logic                    ap_write;
  logic [2:0]              ap_size;
  logic [LANE_W-1:0]       ap_lane;
  logic [WORD_AW-1:0]      ap_word;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                    accept;
  logic                    ap_error;
  logic [6:0]              align_mask;
  logic                    enter_from_wait;
  logic                    enter_direct;
  logic                    enter_data;
  logic                    src_write;
  logic [WORD_AW-1:0]      src_word;
  logic [DATA_BYTES-1:0]   wr_lanes;
  logic                    wr_allow;
  logic [DATA_WIDTH-1:0]   rd_word;

  function automatic logic [DATA_BYTES-1:0] lane_window(input logic [2:0] size,
                                                        input logic [LANE_W-1:0] lane);
    logic [DATA_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTES; i++)
      m[i] = (i >= int'(lane)) && (i < int'(lane) + (1 << size));
    return m;
  endfunction

  // New address phases are only taken while our own data phase is not stalling the bus
  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] &
                  ((state == S_IDLE) | (state == S_DATA) | (state == S_ERR2));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    align_mask = (7'd1 << bus.HSIZE) - 7'd1;
    ap_error   = 1'b0;
    if ({1'b0, bus.HADDR} >= BYTE_RANGE)        ap_error = 1'b1;
    if (|(bus.HADDR[6:0] & align_mask))         ap_error = 1'b1;
    if (bus.HSIZE > 3'(LANE_W))                 ap_error = 1'b1;
  end

  // The transfer whose data phase starts next cycle comes either from the wait counter or straight off the bus
  assign enter_from_wait = (state == S_WAIT) && (wait_cnt == 4'd0);
  assign enter_direct    = accept && !ap_error && (WAIT_STATES == 0);
  assign enter_data      = enter_from_wait | enter_direct;
  assign src_write       = enter_from_wait ? ap_write : bus.HWRITE;
  assign src_word        = enter_from_wait ? ap_word  : bus.HADDR[LANE_W +: WORD_AW];

  assign wr_lanes = (state == S_DATA && ap_write && wr_allow)
                  ? (lane_window(ap_size, ap_lane) & bus.HWSTRB) : '0;

  // Read data merges any lanes being committed on the same edge (read-after-write forwarding)
  always_comb begin
    rd_word = mem[src_word];
    if (ap_word == src_word)
      for (int b = 0; b < DATA_BYTES; b++)
        if (wr_lanes[b]) rd_word[8*b +: 8] = bus.HWDATA[8*b +: 8];
  end

  // NOTE: the storage array is deliberately left out of reset; only control state is reset.
  always_ff @(posedge HCLK) begin
    for (int b = 0; b < DATA_BYTES; b++)
      if (wr_lanes[b] && !HRESET) mem[ap_word][8*b +: 8] <= bus.HWDATA[8*b +: 8];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      ap_write    <= 1'b0;
      ap_size     <= '0;
      ap_lane     <= '0;
      ap_word     <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state       <= S_DATA;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state       <= S_ERR2;
          hreadyout_q <= 1'b1;
        end
        S_IDLE, S_DATA, S_ERR2: begin
          if (accept) begin
            ap_write <= bus.HWRITE;
            ap_size  <= bus.HSIZE;
            ap_lane  <= bus.HADDR[LANE_W-1:0];
            ap_word  <= bus.HADDR[LANE_W +: WORD_AW];
            if (ap_error) begin
              state       <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state       <= S_WAIT;
              wait_cnt    <= 4'(WAIT_STATES - 1);
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
            end else begin
              state       <= S_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
            end
          end else begin
            state       <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
      endcase
      if (enter_data && !src_write) hrdata_q <= rd_word;
    end
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = hrdata_q;

  // Burst type and BUSY are informational: every beat is decoded on its own
  wire unused_bus = &{1'b0, bus.HBURST, bus.HTRANS[0]};

`ifdef AHB5_EXCL_EN
  logic                    ap_excl;
  logic [MASTER_WIDTH-1:0] ap_master;
  logic                    src_excl;
  logic [MASTER_WIDTH-1:0] src_master;
  logic                    resv_valid, resv_valid_nx;
  logic [WORD_AW-1:0]      resv_word, resv_word_nx;
  logic [MASTER_WIDTH-1:0] resv_master, resv_master_nx;
  logic                    excl_match;
  logic                    hexokay_q;

  assign src_excl   = enter_from_wait ? ap_excl   : bus.HEXCL;
  assign src_master = enter_from_wait ? ap_master : bus.HMASTER;

  // A failed exclusive write still completes OKAY but must not touch memory
  assign wr_allow = !ap_excl || hexokay_q;

  // Reservation changes take effect at the end of the data phase that causes them
  always_comb begin
    resv_valid_nx  = resv_valid;
    resv_word_nx   = resv_word;
    resv_master_nx = resv_master;
    if (state == S_DATA) begin
      if (ap_excl && !ap_write) begin
        resv_valid_nx  = 1'b1;
        resv_word_nx   = ap_word;
        resv_master_nx = ap_master;
      end else if (ap_excl && hexokay_q) begin
        resv_valid_nx = 1'b0;
      end else if (!ap_excl && (|wr_lanes) && (ap_word == resv_word)) begin
        resv_valid_nx = 1'b0;
      end
    end
  end

  assign excl_match = resv_valid_nx && (resv_word_nx == src_word) && (resv_master_nx == src_master);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ap_excl     <= 1'b0;
      ap_master   <= '0;
      resv_valid  <= 1'b0;
      resv_word   <= '0;
      resv_master <= '0;
      hexokay_q   <= 1'b0;
    end else begin
      if (accept) begin
        ap_excl   <= bus.HEXCL;
        ap_master <= bus.HMASTER;
      end
      resv_valid  <= resv_valid_nx;
      resv_word   <= resv_word_nx;
      resv_master <= resv_master_nx;
      hexokay_q   <= enter_data && src_excl && (!src_write || excl_match);
    end
  end

  assign bus.HEXOKAY = hexokay_q;
`else
  assign wr_allow    = 1'b1;
  assign bus.HEXOKAY = 1'b0;
  wire unused_excl   = &{1'b0, bus.HEXCL, bus.HMASTER};
`endif

endmodule
